matdet4_stream: RTL and testbench
=================================

Name: matdet4_stream

Overview:
- Serial front end for the combinational 4x4 determinant stage.
- Accepts 16 matrix elements one per handshake, in row-major order, and assembles them into the flat matrix bus that feeds the determinant stage.
- Holds the matrix stable while the determinant settles, registers the returned determinant, and presents it on a valid/ready output.
- Lets a sequential producer (sensor/transform pipeline) drive the determinant datapath without a 128-bit parallel interface.

Parameters:
- DATA_WIDTH, 8, width of one matrix element and of the determinant.
- MATRIX_SIZE, 16, element count. Fixed at 16 for a 4x4 matrix; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  next matrix element, row-major.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an element.
- mat  output  MATRIX_SIZE*DATA_WIDTH  assembled matrix to the determinant stage. Element i (row i/4, column i%4) sits at [i*DATA_WIDTH +: DATA_WIDTH]; element 0 is at the LSBs.
- det_in  input  DATA_WIDTH  determinant returned combinationally by the downstream stage for the current mat.
- out_det  output  DATA_WIDTH  registered determinant.
- out_valid  output  1  out_det is valid.
- out_ready  input  1  consumer accepts out_det.
- out_singular  output  1  only when DET_SINGULAR_EN is defined.

Behaviour:
- Reset (asynchronous, rst_n low): state=LOAD, idx=0, mat=0, out_det=0, out_valid=0, in_ready=1, out_singular=0.
- FSM states: LOAD, EVAL, DONE.
- LOAD:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: mat slot idx <= in_data, idx <= idx+1.
  - When the accepted element has idx==15: idx <= 0, state <= EVAL.
  - in_valid low: hold state and idx.
- EVAL:
  - One cycle. in_ready=0; mat is stable.
  - At the edge: out_det <= det_in, out_valid <= 1, state <= DONE.
- DONE:
  - in_ready=0; out_valid=1; out_det and mat held stable.
  - On an edge with out_ready high: out_valid <= 0, state <= LOAD.
  - Never drop out_valid without out_ready.
- Latency: if the 16th element is accepted at edge k, out_valid is high after edge k+1. One full matrix-to-result cycle is a minimum of 18 edges (16 loads, EVAL, DONE handshake).
- mat is not cleared between matrices. Slots are overwritten in order. A partially loaded matrix exposes old and new elements mixed; this is harmless because det_in is sampled only in EVAL.
- out_ready high in LOAD/EVAL: ignored.
- Simultaneous out_ready and in_valid in DONE: only the output handshake completes. The element is not accepted because in_ready=0. The next element is accepted in the following cycle.
- Reset mid-load or mid-DONE: partial matrix and any pending result are discarded; all reset values above apply.
- Arithmetic: the determinant is modulo 2^DATA_WIDTH, produced by truncating add/sub/mul in the downstream stage. The block applies no extension or saturation.
- idx width: 4 bits. It must not wrap other than via the explicit reset-to-0 at idx==15.

Optional Feature:
- Macro: DET_SINGULAR_EN.
- Defined: adds port out_singular, registered in EVAL alongside out_det as (det_in == 0). It is valid whenever out_valid=1, holds in DONE, and resets to 0.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package (matrix_pkg):
  - constants MAT_DIM=4 and MAT_ELEMS=16;
  - element-index-to-bit-offset function (i*DATA_WIDTH);
  - FSM state typedef {LOAD, EVAL, DONE}.
- The determinant stage is not instantiated inside this block; mat and det_in connect to it at the parent level.
- One natural sub-module: matload_shift, the element-slot register file plus write-index counter, kept separate from the handshake FSM.

Test Plan:
- Identity matrix (1 on diagonal at indices 0,5,10,15, else 0), in_valid held high, out_ready high → out_valid one edge after the 16th accept; out_det=1; out_singular=0.
- Diagonal 2,3,4,5 (DATA_WIDTH=8) → out_det=120. Diagonal 4,4,4,4 → out_det=0 (256 mod 256), out_singular=1.
- Backpressure: after the result, hold out_ready low 5 cycles → out_valid=1, in_ready=0, out_det and mat unchanged. Raise out_ready → out_valid=0 next edge, in_ready=1.
- Gapped input: in_valid toggled 1,0,1,0 across 16 elements of a matrix with det=0xFE → exactly 16 accepts, idx never skips, out_det=0xFE.
- Reset mid-load: assert rst_n low after 7 accepts → mat=0, idx=0, out_valid=0 immediately. Then a full identity load → out_det=1.
- Back-to-back: two matrices (det 1 then 120) with out_ready high throughout → two results in order; in_ready low only during EVAL and DONE.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the 4x4 determinant streaming front end.
//   MAT_DIM / MAT_ELEMS : matrix geometry (4x4, 16 elements)
//   IDX_W               : width of the element write index (0..15)
//   state_t             : handshake FSM states {LOAD, EVAL, DONE}
//   elem_offset()       : bit offset of element i inside the flat matrix bus
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int MAT_DIM   = 4;
  localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element i (row i/4, column i%4) lives at [i*width +: width]; element 0 at the LSBs.
  function automatic int elem_offset(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/matload_shift.sv
// -----------------------------------------------------------------------------
// matload_shift
// Element-slot register file plus write-index counter. Each write stores
// i_wr_data into the slot addressed by the internal index and advances the
// index; after slot MATRIX_SIZE-1 the index returns to 0. Slots are never
// cleared between matrices, only overwritten in order.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears slots and index)
//   i_wr_en    in   write the next slot this cycle
//   i_wr_data  in   element value to write
//   o_mat      out  flat matrix bus, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_last     out  index currently points at the final slot
// -----------------------------------------------------------------------------
module matload_shift
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = MAT_ELEMS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_wr_en,
  input  logic [DATA_WIDTH-1:0]             i_wr_data,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] o_mat,
  output logic                              o_last
);

  logic [MATRIX_SIZE*DATA_WIDTH-1:0] r_mat;
  logic [IDX_W-1:0]                  r_idx;
  logic                              w_last;

  assign w_last = (r_idx == IDX_W'(MATRIX_SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat <= '0;
      r_idx <= '0;
    end else if (i_wr_en) begin
      r_mat[elem_offset(int'(r_idx), DATA_WIDTH) +: DATA_WIDTH] <= i_wr_data;
      // Explicit return to 0 after the last slot; the counter never free-wraps.
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  assign o_mat  = r_mat;
  assign o_last = w_last;

endmodule

// File: rtl/matdet4_stream.sv
// -----------------------------------------------------------------------------
// matdet4_stream
// Serial front end for a combinational 4x4 determinant stage. Sixteen
// elements arrive one per in_valid/in_ready handshake in row-major order and
// are assembled onto the flat 'mat' bus. After the 16th element the block
// spends one EVAL cycle with 'mat' stable, captures the determinant returned
// on det_in, and presents it on an out_valid/out_ready interface (DONE).
// The determinant stage itself lives in the parent; only mat/det_in cross.
//
// Only MATRIX_SIZE = 16 (4x4) is supported.
//
// Optional feature (macro DET_SINGULAR_EN): adds out_singular, registered in
// EVAL as (det_in == 0) and held with out_det. Without the macro the port and
// its register are absent.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_data      in   next matrix element (row-major)
//   in_valid     in   in_data is valid
//   in_ready     out  block can accept an element (high only in LOAD)
//   mat          out  assembled matrix to the determinant stage
//   det_in       in   determinant of 'mat' from the downstream stage
//   out_det      out  registered determinant (mod 2^DATA_WIDTH, no saturation)
//   out_valid    out  out_det is valid
//   out_ready    in   consumer accepts out_det
//   out_singular out  determinant was zero (DET_SINGULAR_EN only)
// -----------------------------------------------------------------------------
module matdet4_stream
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = MAT_ELEMS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] mat,
  input  logic [DATA_WIDTH-1:0]             det_in,
  output logic [DATA_WIDTH-1:0]             out_det,
  output logic                              out_valid,
  input  logic                              out_ready
`ifdef DET_SINGULAR_EN
  ,
  output logic                              out_singular
`endif
);

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_det;
`ifdef DET_SINGULAR_EN
  logic                    r_out_singular;
`endif

  logic                    w_accept;
  logic                    w_last;

  // r_in_ready is high only in LOAD, so it alone qualifies an accept.
  assign w_accept = in_valid && r_in_ready;

  matload_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MATRIX_SIZE (MATRIX_SIZE)
  ) u_load (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_data (in_data),
    .o_mat     (mat),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_det   <= '0;
`ifdef DET_SINGULAR_EN
      r_out_singular <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          // Leave LOAD as soon as the final slot is written; ready drops the
          // same edge so nothing is accepted while the determinant settles.
          if (w_accept && w_last) begin
            r_state    <= EVAL;
            r_in_ready <= 1'b0;
          end
        end
        EVAL: begin
          r_out_det   <= det_in;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
`ifdef DET_SINGULAR_EN
          r_out_singular <= (det_in == '0);
`endif
        end
        DONE: begin
          // Result held until the consumer takes it; an element offered in
          // the same cycle waits for the next one because in_ready is low.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= LOAD;
          end
        end
        default: begin
          r_state     <= LOAD;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_det   = r_out_det;
`ifdef DET_SINGULAR_EN
  assign out_singular = r_out_singular;
`endif

endmodule

// File: tb/tb_matdet4_stream.sv
module tb_matdet4_stream;

  localparam int DW = 8;
  localparam int MS = 16;

  typedef logic [7:0] mat_t [16];
  typedef struct {
    logic [7:0]   det;
    logic         sing;
    logic [127:0] m;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [MS*DW-1:0] mat;
  logic [DW-1:0]   det_in;
  logic [DW-1:0]   out_det;
  logic            out_valid;
  logic            out_ready = 1'b0;
`ifdef DET_SINGULAR_EN
  logic            out_singular;
`endif

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_cnt  = 0;
  int   ready_mode = 1;   // 0: out_ready low, 1: high, 2: random

  matdet4_stream #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat       (mat),
    .det_in    (det_in),
    .out_det   (out_det),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DET_SINGULAR_EN
    ,
    .out_singular (out_singular)
`endif
  );

  always #5 clk = ~clk;

  // Leibniz determinant over all 24 permutations, reduced mod 256.
  function automatic int det4(input int m[16]);
    longint s;
    longint term;
    int     p[4];
    int     inv;
    s = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++) begin
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              p[0] = a; p[1] = b; p[2] = c; p[3] = d;
              inv = 0;
              for (int x = 0; x < 4; x++)
                for (int y = x + 1; y < 4; y++)
                  if (p[x] > p[y]) inv++;
              term = longint'(m[a]) * m[4 + b] * m[8 + c] * m[12 + d];
              if (inv % 2 == 1) s = s - term;
              else              s = s + term;
            end
          end
    return int'(s & 64'hFF);
  endfunction

  // Downstream combinational determinant stage.
  always_comb begin
    int mm[16];
    for (int i = 0; i < 16; i++) mm[i] = int'(mat[i*DW +: DW]);
    det_in = DW'(det4(mm));
  end

  function automatic logic [127:0] pack(input mat_t m);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = m[i];
    return v;
  endfunction

  function automatic mat_t diag(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
    mat_t m;
    for (int i = 0; i < 16; i++) m[i] = 8'd0;
    m[0] = a; m[5] = b; m[10] = c; m[15] = d;
    return m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // out_ready driver: the only writer of out_ready.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Accept counter.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) acc_cnt++;
    end
  end

  // Scoreboard monitor: compare on every new result.
  initial begin
    bit prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (out_valid && !prev) begin
          chk("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("res_det", 128'(out_det), 128'(e.det));
            chk("res_mat", mat, e.m);
            chk("res_in_ready", 128'(in_ready), 128'd0);
`ifdef DET_SINGULAR_EN
            chk("res_singular", 128'(out_singular), 128'(e.sing));
`endif
          end
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (out_valid) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        $display("FAIL idle_timeout: out_valid stuck at %0b expected 0", out_valid);
        $fatal(1, "idle timeout");
      end
    end
  endtask

  // Issue n elements of m; a full matrix pushes its expected result first.
  task automatic send_matrix(input mat_t m, input int n, input bit gap);
    int   mm[16];
    exp_t e;
    int   t;
    if (n == 16) begin
      for (int i = 0; i < 16; i++) mm[i] = int'(m[i]);
      e.det  = 8'(det4(mm));
      e.sing = (e.det == 8'd0);
      e.m    = pack(m);
      sb_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      in_data  = m[i];
      in_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
        if (t > 200) begin
          $display("FAIL accept_timeout: in_ready %0b expected 1 at element %0d", in_ready, i);
          $fatal(1, "accept timeout");
        end
      end while (!in_ready);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap && i != n - 1) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (n == 16) begin
      chk("eval_valid", 128'(out_valid), 128'd0);
      chk("eval_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      chk("done_valid", 128'(out_valid), 128'd1);
      chk("done_in_ready", 128'(in_ready), 128'd0);
    end
  endtask

  initial begin
    mat_t m;
    mat_t ident;
    int   acc0;
    int   mm[16];
    logic [7:0] bp_det;
    int   t;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ident    = diag(8'd1, 8'd1, 8'd1, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mat", mat, 128'd0);
    chk("rst_out_det", 128'(out_det), 128'd0);
`ifdef DET_SINGULAR_EN
    chk("rst_singular", 128'(out_singular), 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back with out_ready high.
    ready_mode = 1;
    send_matrix(ident, 16, 1'b0);
    send_matrix(diag(8'd2, 8'd3, 8'd4, 8'd5), 16, 1'b0);
    send_matrix(diag(8'd4, 8'd4, 8'd4, 8'd4), 16, 1'b0);
    wait_idle();

    // Backpressure.
    ready_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) m[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mm[i] = int'(m[i]);
    bp_det = 8'(det4(mm));
    send_matrix(m, 16, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_det", 128'(out_det), 128'(bp_det));
      chk("bp_mat", mat, pack(m));
    end
    ready_mode = 1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);

    // Gapped input, upper-triangular with det 0xFE.
    for (int i = 0; i < 16; i++) m[i] = ((i % 4) > (i / 4)) ? 8'($urandom) : 8'd0;
    m[0] = 8'hFE; m[5] = 8'd1; m[10] = 8'd1; m[15] = 8'd1;
    acc0 = acc_cnt;
    send_matrix(m, 16, 1'b1);
    chk("gap_accepts", 128'(acc_cnt - acc0), 128'd16);
    wait_idle();

    // Reset mid-load.
    for (int i = 0; i < 16; i++) m[i] = 8'($urandom);
    send_matrix(m, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mat", mat, 128'd0);
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_matrix(ident, 16, 1'b0);
    wait_idle();

    // Randomized matrices with random gaps and random consumer backpressure.
    ready_mode = 2;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 16; i++) m[i] = 8'($urandom);
      send_matrix(m, 16, 1'($urandom_range(0, 1)));
    end
    ready_mode = 1;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    wait_idle();
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
